useq_ctrl: RTL and testbench

USEQ_CTRL -- requirements
Module: useq_ctrl

---
 rtl/useq_ctrl.sv | 178 +++++++++++++++++
 tb/tb_useq_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/useq_ctrl.sv
// Microprogrammed sequencer: loadable control store and dispatch table,
// one microword per clock, with a bounded micro-call stack and error latching.
module useq_ctrl #(
  parameter int unsigned OPC_W      = 8,
  parameter int unsigned UADDR_W    = 8,
  parameter int unsigned CW_W       = 29,
  parameter int unsigned FLAG_W     = 4,
  parameter int unsigned STK_D      = 4,
  parameter int unsigned START_ADDR = 0,
  localparam int unsigned CS_W      = $clog2(FLAG_W),
  localparam int unsigned UW        = 3 + UADDR_W + CS_W + 1 + CW_W,
  localparam int unsigned LD_AW     = (UADDR_W > OPC_W) ? UADDR_W : OPC_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               halted,
  output logic [1:0]         err,
  input  logic [OPC_W-1:0]   instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [FLAG_W-1:0]  flags,
  output logic [CW_W-1:0]    ctrl_signals,
  input  logic               ld_en,
  input  logic               ld_sel,
  input  logic [LD_AW-1:0]   ld_addr,
  input  logic [UW-1:0]      ld_data,
  output logic [UADDR_W-1:0] uaddr,
  output logic [1:0]         state
);

  localparam int unsigned SP_W  = $clog2(STK_D + 1);
  localparam int unsigned STK_N = 1 << SP_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2,
    ST_ERR  = 2'd3
  } st_e;

  typedef enum logic [2:0] {
    OP_NEXT     = 3'd0,
    OP_JUMP     = 3'd1,
    OP_CJUMP    = 3'd2,
    OP_DISPATCH = 3'd3,
    OP_CALL     = 3'd4,
    OP_RET      = 3'd5,
    OP_FETCH    = 3'd6,
    OP_HALT     = 3'd7
  } op_e;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_OVF  = 2'd1;
  localparam logic [1:0] ERR_UNF  = 2'd2;

  logic [UW-1:0]      cstore [2**UADDR_W];
  logic [UADDR_W-1:0] dtable [2**OPC_W];
  logic [UADDR_W-1:0] stack  [STK_N];

  st_e                st_q, st_d;
  logic [UADDR_W-1:0] uaddr_q, uaddr_d;
  logic [SP_W-1:0]    sp_q, sp_d;
  logic [1:0]         err_q, err_d;
  logic [OPC_W-1:0]   iq_q, iq_d;
  logic               push;
  logic               ld_we;

  logic [UW-1:0]      uw;
  op_e                op;
  logic [UADDR_W-1:0] tgt;
  logic [UADDR_W-1:0] uaddr_inc;
  logic [CS_W-1:0]    csel;
  logic               cpol;
  logic [CW_W-1:0]    cw;

  // Microword field decode of the current store entry
  assign uw        = cstore[uaddr_q];
  assign op        = op_e'(uw[2:0]);
  assign tgt       = uw[3 +: UADDR_W];
  assign csel      = uw[3 + UADDR_W +: CS_W];
  assign cpol      = uw[3 + UADDR_W + CS_W];
  assign cw        = uw[UW-1 -: CW_W];
  assign uaddr_inc = uaddr_q + UADDR_W'(1);

  // Program loading is locked out while running or when start wins the cycle
  assign ld_we = ld_en && (st_q != ST_RUN) && !start;

  always_ff @(posedge clk) begin
    if (ld_we && !ld_sel) cstore[ld_addr[UADDR_W-1:0]] <= ld_data;
    if (ld_we && ld_sel)  dtable[ld_addr[OPC_W-1:0]]   <= ld_data[UADDR_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (push) stack[sp_q] <= uaddr_inc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= ST_IDLE;
      uaddr_q <= '0;
      sp_q    <= '0;
      err_q   <= ERR_NONE;
      iq_q    <= '0;
    end else begin
      st_q    <= st_d;
      uaddr_q <= uaddr_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
      iq_q    <= iq_d;
    end
  end

  // Sequencing: next state, next micro-address, stack and fetch handshake
  always_comb begin
    st_d         = st_q;
    uaddr_d      = uaddr_q;
    sp_d         = sp_q;
    err_d        = err_q;
    iq_d         = iq_q;
    push         = 1'b0;
    instr_ready  = 1'b0;
    ctrl_signals = '0;
    case (st_q)
      ST_RUN: begin
        ctrl_signals = cw;
        case (op)
          OP_NEXT:     uaddr_d = uaddr_inc;
          OP_JUMP:     uaddr_d = tgt;
          OP_CJUMP:    uaddr_d = (flags[csel] ^ cpol) ? tgt : uaddr_inc;
          OP_DISPATCH: uaddr_d = dtable[iq_q];
          OP_CALL: begin
            if (sp_q == SP_W'(STK_D)) begin
              st_d  = ST_ERR;
              err_d = ERR_OVF;
            end else begin
              push    = 1'b1;
              sp_d    = sp_q + SP_W'(1);
              uaddr_d = tgt;
            end
          end
          OP_RET: begin
            if (sp_q == '0) begin
              st_d  = ST_ERR;
              err_d = ERR_UNF;
            end else begin
              sp_d    = sp_q - SP_W'(1);
              uaddr_d = stack[sp_q - SP_W'(1)];
            end
          end
          OP_FETCH: begin
            if (instr_valid) begin
              iq_d        = instr;
              instr_ready = 1'b1;
              uaddr_d     = uaddr_inc;
            end
          end
          OP_HALT: st_d = ST_HALT;
          default: st_d = st_q;
        endcase
      end
      default: begin
        if (start) begin
          st_d    = ST_RUN;
          uaddr_d = UADDR_W'(START_ADDR);
          sp_d    = '0;
          err_d   = ERR_NONE;
        end
      end
    endcase
  end

  assign uaddr  = uaddr_q;
  assign state  = st_q;
  assign err    = err_q;
  assign halted = (st_q == ST_HALT);

endmodule

// File: tb/tb_useq_ctrl.sv
// Bench for useq_ctrl: directed scenarios plus randomized programs checked
// against a queue-based behavioural sequencer model.
`timescale 1ns/1ps
module tb_useq_ctrl;

  localparam int unsigned OPC_W = 8;
  localparam int unsigned UADDR_W = 8;
  localparam int unsigned CW_W = 29;
  localparam int unsigned FLAG_W = 4;
  localparam int unsigned UW = 43;
  localparam int unsigned LD_AW = 8;
  localparam int unsigned DEPTH = 256;

  logic               clk, rst_n, start, halted, instr_valid, instr_ready;
  logic [1:0]         err, state;
  logic [OPC_W-1:0]   instr;
  logic [FLAG_W-1:0]  flags;
  logic [CW_W-1:0]    ctrl_signals;
  logic               ld_en, ld_sel;
  logic [LD_AW-1:0]   ld_addr;
  logic [UW-1:0]      ld_data;
  logic [UADDR_W-1:0] uaddr;

  int n_vec = 0;
  int n_bad = 0;

  // Behavioural model state
  int            m_state, m_uaddr, m_err, m_iq;
  int            m_stack[$];
  logic [UW-1:0] m_store[DEPTH];
  int            m_disp[DEPTH];

  useq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halted(halted), .err(err),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .flags(flags), .ctrl_signals(ctrl_signals),
    .ld_en(ld_en), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
    .uaddr(uaddr), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [UW-1:0] mk(int op, int tgt, int cs, int pol, int ctrl);
    logic [UW-1:0] w;
    w = '0;
    w[2:0]   = 3'(op);
    w[10:3]  = 8'(tgt);
    w[12:11] = 2'(cs);
    w[13]    = 1'(pol);
    w[42:14] = 29'(ctrl);
    return w;
  endfunction

  task automatic model_reset();
    m_state = 0; m_uaddr = 0; m_err = 0; m_iq = 0;
    m_stack.delete();
  endtask

  // One clock of the sequencer rules, using the inputs currently driven
  task automatic model_step();
    logic [UW-1:0] w;
    int op, tgt, cs, pol;
    bit ld_ok;
    ld_ok = ld_en && (m_state != 1) && !start;
    if (m_state != 1) begin
      if (start) begin
        m_state = 1; m_uaddr = 0; m_err = 0; m_stack.delete();
      end
    end else begin
      w = m_store[m_uaddr];
      op = int'(w[2:0]); tgt = int'(w[10:3]); cs = int'(w[12:11]); pol = int'(w[13]);
      case (op)
        0: m_uaddr = (m_uaddr + 1) % 256;
        1: m_uaddr = tgt;
        2: m_uaddr = ((flags[cs] ^ pol[0]) == 1'b1) ? tgt : (m_uaddr + 1) % 256;
        3: m_uaddr = m_disp[m_iq];
        4: if (m_stack.size() == 4) begin m_state = 3; m_err = 1; end
           else begin m_stack.push_back((m_uaddr + 1) % 256); m_uaddr = tgt; end
        5: if (m_stack.size() == 0) begin m_state = 3; m_err = 2; end
           else m_uaddr = m_stack.pop_back();
        6: if (instr_valid) begin m_iq = int'(instr); m_uaddr = (m_uaddr + 1) % 256; end
        default: m_state = 2;
      endcase
    end
    if (ld_ok) begin
      if (ld_sel) m_disp[int'(ld_addr)] = int'(ld_data[7:0]);
      else        m_store[int'(ld_addr)] = ld_data;
    end
  endtask

  task automatic load(input logic sel, input int addr, input logic [UW-1:0] data);
    ld_en = 1'b1; ld_sel = sel; ld_addr = 8'(addr); ld_data = data;
    @(posedge clk); #1;
    ld_en = 1'b0;
    if (sel) m_disp[addr % 256] = int'(data[7:0]);
    else     m_store[addr % 256] = data;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic do_reset();
    start = 1'b0; ld_en = 1'b0; instr_valid = 1'b0;
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
  endtask

  task automatic test_reset();
    #1;
    n_vec++; if (state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state); end
    n_vec++; if ({uaddr, err, halted, instr_ready, ctrl_signals} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: uaddr=%h err=%0d halted=%b rdy=%b ctrl=%h want all 0",
                        uaddr, err, halted, instr_ready, ctrl_signals); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) begin
      load(1'b0, i, mk(7, 0, 0, 0, int'($urandom)));
      load(1'b1, i, '0);
    end
  endtask

  task automatic test_seq();
    load(1'b0, 8'h00, mk(0, 0, 0, 0, 1));
    load(1'b0, 8'h01, mk(1, 8'h10, 0, 0, 2));
    load(1'b0, 8'h10, mk(7, 0, 0, 0, 3));
    do_start();
    n_vec++; if ({state, uaddr, ctrl_signals} !== {2'd1, 8'h00, 29'd1}) begin n_bad++;
      $display("FAIL seq_c0: state=%0d uaddr=%h ctrl=%h want 1 00 1", state, uaddr, ctrl_signals); end
    @(posedge clk); #1;
    n_vec++; if ({state, uaddr, ctrl_signals} !== {2'd1, 8'h01, 29'd2}) begin n_bad++;
      $display("FAIL seq_c1: state=%0d uaddr=%h ctrl=%h want 1 01 2", state, uaddr, ctrl_signals); end
    @(posedge clk); #1;
    n_vec++; if ({state, uaddr, ctrl_signals} !== {2'd1, 8'h10, 29'd3}) begin n_bad++;
      $display("FAIL seq_c2: state=%0d uaddr=%h ctrl=%h want 1 10 3", state, uaddr, ctrl_signals); end
    @(posedge clk); #1;
    n_vec++; if ({halted, state, uaddr, ctrl_signals} !== {1'b1, 2'd2, 8'h10, 29'd0}) begin n_bad++;
      $display("FAIL seq_halt: halted=%b state=%0d uaddr=%h ctrl=%h want 1 2 10 0",
               halted, state, uaddr, ctrl_signals); end
  endtask

  task automatic test_fetch();
    load(1'b0, 8'h00, mk(6, 0, 0, 0, 4));
    load(1'b0, 8'h01, mk(3, 0, 0, 0, 5));
    load(1'b0, 8'h40, mk(7, 0, 0, 0, 6));
    load(1'b1, 8'hA5, UW'(8'h40));
    instr = 8'h3C; instr_valid = 1'b0;
    do_start();
    for (int i = 0; i < 3; i++) begin
      n_vec++; if ({uaddr, instr_ready} !== {8'h00, 1'b0}) begin n_bad++;
        $display("FAIL fetch_wait%0d: uaddr=%h rdy=%b want 00 0", i, uaddr, instr_ready); end
      @(posedge clk); #1;
    end
    instr = 8'hA5; instr_valid = 1'b1; #1;
    n_vec++; if ({uaddr, instr_ready} !== {8'h00, 1'b1}) begin n_bad++;
      $display("FAIL fetch_accept: uaddr=%h rdy=%b want 00 1", uaddr, instr_ready); end
    @(posedge clk); #1;
    instr_valid = 1'b0; instr = 8'h00;
    n_vec++; if ({uaddr, instr_ready} !== {8'h01, 1'b0}) begin n_bad++;
      $display("FAIL fetch_next: uaddr=%h rdy=%b want 01 0", uaddr, instr_ready); end
    @(posedge clk); #1;
    n_vec++; if (uaddr !== 8'h40) begin n_bad++; $display("FAIL dispatch: uaddr=%h want 40", uaddr); end
    @(posedge clk); #1;
  endtask

  task automatic test_cjump();
    logic [7:0] want;
    load(1'b0, 8'h01, mk(7, 0, 0, 0, 0));
    load(1'b0, 8'h20, mk(7, 0, 0, 0, 0));
    for (int pol = 0; pol < 2; pol++) begin
      for (int f = 0; f < 2; f++) begin
        load(1'b0, 8'h00, mk(2, 8'h20, 2, pol, 7));
        flags = (f == 0) ? 4'b0100 : 4'b0000;
        want = ((f == 0) != (pol == 1)) ? 8'h20 : 8'h01;
        do_start();
        @(posedge clk); #1;
        n_vec++; if (uaddr !== want) begin n_bad++;
          $display("FAIL cjump_p%0d_f%h: uaddr=%h want %h", pol, flags, uaddr, want); end
        @(posedge clk); #1;
      end
    end
    flags = '0;
  endtask

  task automatic test_stack();
    load(1'b0, 8'h00, mk(4, 8'h10, 0, 0, 0));
    load(1'b0, 8'h10, mk(4, 8'h20, 0, 0, 0));
    load(1'b0, 8'h20, mk(4, 8'h30, 0, 0, 0));
    load(1'b0, 8'h30, mk(4, 8'h40, 0, 0, 0));
    load(1'b0, 8'h40, mk(4, 8'h50, 0, 0, 0));
    do_start();
    repeat (4) begin @(posedge clk); #1; end
    n_vec++; if ({state, uaddr, err} !== {2'd1, 8'h40, 2'd0}) begin n_bad++;
      $display("FAIL call4: state=%0d uaddr=%h err=%0d want 1 40 0", state, uaddr, err); end
    @(posedge clk); #1;
    n_vec++; if ({state, err, uaddr} !== {2'd3, 2'd1, 8'h40}) begin n_bad++;
      $display("FAIL overflow: state=%0d err=%0d uaddr=%h want 3 1 40", state, err, uaddr); end
    @(posedge clk); #1;
    n_vec++; if ({state, err, ctrl_signals} !== {2'd3, 2'd1, 29'd0}) begin n_bad++;
      $display("FAIL err_hold: state=%0d err=%0d ctrl=%h want 3 1 0", state, err, ctrl_signals); end
    load(1'b0, 8'h00, mk(5, 0, 0, 0, 0));
    do_start();
    n_vec++; if ({state, err} !== {2'd1, 2'd0}) begin n_bad++;
      $display("FAIL start_clr: state=%0d err=%0d want 1 0", state, err); end
    @(posedge clk); #1;
    n_vec++; if ({state, err} !== {2'd3, 2'd2}) begin n_bad++;
      $display("FAIL underflow: state=%0d err=%0d want 3 2", state, err); end
  endtask

  task automatic test_wrap();
    do_reset();
    load(1'b0, 8'h00, mk(1, 8'hFF, 0, 0, 29'h55));
    load(1'b0, 8'hFF, mk(0, 0, 0, 0, 0));
    do_start();
    repeat (2) begin @(posedge clk); #1; end
    n_vec++; if ({state, uaddr} !== {2'd1, 8'h00}) begin n_bad++;
      $display("FAIL next_wrap: state=%0d uaddr=%h want 1 00", state, uaddr); end
    do_reset();
    load(1'b0, 8'hFF, mk(4, 8'h80, 0, 0, 0));
    load(1'b0, 8'h80, mk(5, 0, 0, 0, 0));
    do_start();
    repeat (2) begin @(posedge clk); #1; end
    n_vec++; if (uaddr !== 8'h80) begin n_bad++; $display("FAIL call_ff: uaddr=%h want 80", uaddr); end
    @(posedge clk); #1;
    n_vec++; if ({state, uaddr, err} !== {2'd1, 8'h00, 2'd0}) begin n_bad++;
      $display("FAIL ret_wrap: state=%0d uaddr=%h err=%0d want 1 00 0", state, uaddr, err); end
  endtask

  task automatic test_midrun_reset();
    ld_en = 1'b1; ld_sel = 1'b0; ld_addr = 8'h00; ld_data = mk(7, 0, 0, 0, 29'h1234);
    repeat (3) begin @(posedge clk); #1; end
    ld_en = 1'b0;
    n_vec++; if (state !== 2'd1) begin n_bad++; $display("FAIL run_during_ld: state=%0d want 1", state); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if ({state, uaddr, err, halted, instr_ready, ctrl_signals} !== '0) begin n_bad++;
      $display("FAIL async_reset: state=%0d uaddr=%h err=%0d halted=%b rdy=%b ctrl=%h want all 0",
               state, uaddr, err, halted, instr_ready, ctrl_signals); end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    n_vec++; if ({state, uaddr} !== {2'd0, 8'h00}) begin n_bad++;
      $display("FAIL idle_after_rst: state=%0d uaddr=%h want 0 00", state, uaddr); end
    do_start();
    n_vec++; if (ctrl_signals !== 29'h55) begin n_bad++;
      $display("FAIL store_kept: ctrl=%h want 55", ctrl_signals); end
    @(posedge clk); #1;
    n_vec++; if ({state, uaddr} !== {2'd1, 8'hFF}) begin n_bad++;
      $display("FAIL store_kept_seq: state=%0d uaddr=%h want 1 ff", state, uaddr); end
  endtask

  task automatic test_random();
    logic [42:0] obs, exp;
    logic [CW_W-1:0] ec;
    logic er;
    for (int p = 0; p < 4; p++) begin
      do_reset();
      for (int a = 0; a < 256; a++) begin
        load(1'b0, a, UW'({$urandom, $urandom}));
        load(1'b1, a, UW'($urandom_range(255)));
      end
      for (int c = 0; c < 250; c++) begin
        start = ($urandom_range(7) == 0);
        flags = 4'($urandom);
        instr = 8'($urandom);
        instr_valid = 1'($urandom);
        ld_en = ($urandom_range(15) == 0);
        ld_sel = 1'($urandom);
        ld_addr = 8'($urandom);
        ld_data = UW'({$urandom, $urandom});
        @(negedge clk);
        ec = (m_state == 1) ? m_store[m_uaddr][42:14] : '0;
        er = (m_state == 1) && (m_store[m_uaddr][2:0] == 3'd6) && instr_valid;
        exp = {2'(m_state), 8'(m_uaddr), 2'(m_err), (m_state == 2), er, ec};
        obs = {state, uaddr, err, halted, instr_ready, ctrl_signals};
        n_vec++; if (obs !== exp) begin n_bad++;
          $display("FAIL rand_p%0d_c%0d: got %h want %h", p, c, obs, exp); end
        model_step();
        @(posedge clk); #1;
      end
      start = 1'b0; ld_en = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; instr = '0; instr_valid = 1'b0; flags = '0;
    ld_en = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0;
    model_reset();
    test_reset();
    fill_mem();
    test_seq();
    test_fetch();
    test_cjump();
    test_stack();
    test_wrap();
    test_midrun_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
